// File: rtl/rsp_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rsp_fifo_arbiter
// Description : Two fire-and-forget response producers share one response
//               FIFO write port. Each producer feeds a small elastic queue,
//               and a round-robin grant drains the queues into the FIFO while
//               honouring its almost_full.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 4
`endif

module rsp_fifo_arbiter #(
  parameter int QDEPTH       = 4,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s0_write_en,
  input  logic [`REQ_ID_WIDTH-1:0]       s0_id,
  input  logic [`ALL_PAGE_IDX_WIDTH-1:0] s0_page_idx,
  input  logic                           s0_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]  s0_fail_reason,
  input  logic                           s1_write_en,
  input  logic [`REQ_ID_WIDTH-1:0]       s1_id,
  input  logic [`ALL_PAGE_IDX_WIDTH-1:0] s1_page_idx,
  input  logic                           s1_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]  s1_fail_reason,
  output logic                           s0_almost_full,
  output logic                           s1_almost_full,
  output logic                           rsp_write_en,
  output logic [`REQ_ID_WIDTH-1:0]       rsp_id,
  output logic [`ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx,
  output logic                           rsp_fail,
  output logic [`FAIL_REASON_WIDTH-1:0]  rsp_fail_reason,
  input  logic                           rsp_fifo_almost_full,
  output logic [7:0]                     s0_drop_count,
  output logic [7:0]                     s1_drop_count,
  output logic                           busy
);

  localparam int IDW = `REQ_ID_WIDTH;
  localparam int PGW = `ALL_PAGE_IDX_WIDTH;
  localparam int FRW = `FAIL_REASON_WIDTH;
  localparam int EW  = IDW + PGW + 1 + FRW;
  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(QDEPTH);
  localparam logic [CW-1:0] C_AF_TH = CW'(QDEPTH - AFULL_MARGIN);

  // Queue storage and bookkeeping, indexed by source
  logic [EW-1:0]  mem_q   [2][QDEPTH];
  logic [PW-1:0]  wptr_q  [2];
  logic [PW-1:0]  rptr_q  [2];
  logic [CW-1:0]  cnt_q   [2];
  logic [CW-1:0]  cnt_d   [2];
  logic [7:0]     drop_q  [2];
  logic [1:0]     afull_q;
  logic           rr_last_q;

  // Registered response port
  logic            rsp_we_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [PGW-1:0]  rsp_pg_q;
  logic            rsp_fail_q;
  logic [FRW-1:0]  rsp_fr_q;

  // Combinational grant / push decisions
  logic [1:0]      push_req;
  logic [EW-1:0]   push_data [2];
  logic [1:0]      nonempty;
  logic [1:0]      pop;
  logic [1:0]      accept;
  logic            eligible;
  logic            gnt_src;
  logic [EW-1:0]   head;
  logic [IDW-1:0]  head_id;
  logic [PGW-1:0]  head_pg;
  logic            head_fail;
  logic [FRW-1:0]  head_fr;

  // Grant from registered state; a full queue may still accept when it is popped
  always_comb begin
    push_req     = {s1_write_en, s0_write_en};
    push_data[0] = {s0_id, s0_page_idx, s0_fail, s0_fail_reason};
    push_data[1] = {s1_id, s1_page_idx, s1_fail, s1_fail_reason};
    nonempty     = {(cnt_q[1] != '0), (cnt_q[0] != '0)};
    eligible     = !rsp_fifo_almost_full && (nonempty != 2'b00);
    // Source 1 wins when it is alone, or on a tie when source 0 went last
    gnt_src      = nonempty[1] && (!nonempty[0] || !rr_last_q);
    pop          = {eligible && gnt_src, eligible && !gnt_src};
    for (int s = 0; s < 2; s++) begin
      accept[s] = push_req[s] && ((cnt_q[s] < C_DEPTH) || pop[s]);
      cnt_d[s]  = cnt_q[s] + CW'(accept[s]) - CW'(pop[s]);
    end
    head = mem_q[gnt_src][rptr_q[gnt_src]];
    {head_id, head_pg, head_fail, head_fr} = head;
  end

  // Queue storage writes; contents need no reset since pointers/counts gate them
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (accept[s]) begin
        mem_q[s][wptr_q[s]] <= push_data[s];
      end
    end
  end

  // Pointers, counts, flags, round-robin state and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
        drop_q[s] <= '0;
      end
      afull_q    <= '0;
      rr_last_q  <= 1'b1;
      rsp_we_q   <= 1'b0;
      rsp_id_q   <= '0;
      rsp_pg_q   <= '0;
      rsp_fail_q <= 1'b0;
      rsp_fr_q   <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (accept[s]) begin
          wptr_q[s] <= wptr_q[s] + PW'(1);
        end
        if (pop[s]) begin
          rptr_q[s] <= rptr_q[s] + PW'(1);
        end
        cnt_q[s]   <= cnt_d[s];
        afull_q[s] <= (cnt_d[s] >= C_AF_TH);
        if (push_req[s] && !accept[s] && (drop_q[s] != 8'hFF)) begin
          drop_q[s] <= drop_q[s] + 8'd1;
        end
      end
      if (eligible) begin
        rr_last_q  <= gnt_src;
        rsp_we_q   <= 1'b1;
        rsp_id_q   <= head_id;
        rsp_pg_q   <= head_pg;
        rsp_fail_q <= head_fail;
        rsp_fr_q   <= head_fr;
      end else begin
        rsp_we_q   <= 1'b0;
        rsp_id_q   <= '0;
        rsp_pg_q   <= '0;
        rsp_fail_q <= 1'b0;
        rsp_fr_q   <= '0;
      end
    end
  end

  assign s0_almost_full  = afull_q[0];
  assign s1_almost_full  = afull_q[1];
  assign s0_drop_count   = drop_q[0];
  assign s1_drop_count   = drop_q[1];
  assign rsp_write_en    = rsp_we_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_page_idx    = rsp_pg_q;
  assign rsp_fail        = rsp_fail_q;
  assign rsp_fail_reason = rsp_fr_q;
  assign busy            = (nonempty != 2'b00) || rsp_we_q;

endmodule

`default_nettype wire

// File: tb/tb_rsp_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsp_fifo_arbiter
// Description : Scenario testbench for rsp_fifo_arbiter with an ordered
//               scoreboard of expected response-FIFO writes.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 4
`endif

module tb_rsp_fifo_arbiter;

  localparam int IDW = `REQ_ID_WIDTH;
  localparam int PGW = `ALL_PAGE_IDX_WIDTH;
  localparam int FRW = `FAIL_REASON_WIDTH;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PGW-1:0] pg;
    logic           f;
    logic [FRW-1:0] r;
  } ent_t;

  logic           clk;
  logic           rst;
  logic           s0_write_en, s1_write_en;
  logic [IDW-1:0] s0_id, s1_id;
  logic [PGW-1:0] s0_page_idx, s1_page_idx;
  logic           s0_fail, s1_fail;
  logic [FRW-1:0] s0_fail_reason, s1_fail_reason;
  logic           s0_almost_full, s1_almost_full;
  logic           rsp_write_en;
  logic [IDW-1:0] rsp_id;
  logic [PGW-1:0] rsp_page_idx;
  logic           rsp_fail;
  logic [FRW-1:0] rsp_fail_reason;
  logic           rsp_fifo_almost_full;
  logic [7:0]     s0_drop_count, s1_drop_count;
  logic           busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  ent_t sb[$];

  rsp_fifo_arbiter #(.QDEPTH(4), .AFULL_MARGIN(1)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s0_write_en          (s0_write_en),
    .s0_id                (s0_id),
    .s0_page_idx          (s0_page_idx),
    .s0_fail              (s0_fail),
    .s0_fail_reason       (s0_fail_reason),
    .s1_write_en          (s1_write_en),
    .s1_id                (s1_id),
    .s1_page_idx          (s1_page_idx),
    .s1_fail              (s1_fail),
    .s1_fail_reason       (s1_fail_reason),
    .s0_almost_full       (s0_almost_full),
    .s1_almost_full       (s1_almost_full),
    .rsp_write_en         (rsp_write_en),
    .rsp_id               (rsp_id),
    .rsp_page_idx         (rsp_page_idx),
    .rsp_fail             (rsp_fail),
    .rsp_fail_reason      (rsp_fail_reason),
    .rsp_fifo_almost_full (rsp_fifo_almost_full),
    .s0_drop_count        (s0_drop_count),
    .s1_drop_count        (s1_drop_count),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t mk(input int id, input bit f, input int r);
    ent_t e;
    e.id = IDW'(id);
    e.pg = PGW'(id + 100);
    e.f  = f;
    e.r  = FRW'(r);
    return e;
  endfunction

  // Scoreboard: every response-FIFO write must match the oldest expected entry
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      n_checks++;
      if (rsp_write_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_write: got id=%0d, required no write", rsp_id);
        end else begin
          ent_t e;
          e = sb.pop_front();
          if ({rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason} !== e) begin
            n_fail++;
            $display("FAIL sb_entry: got id=%0d pg=%0d f=%0b r=%0d, required id=%0d pg=%0d f=%0b r=%0d",
                     rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason, e.id, e.pg, e.f, e.r);
          end
        end
      end else if (rsp_write_en === 1'b0) begin
        if ({rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason} !== '0) begin
          n_fail++;
          $display("FAIL sb_idle_zero: got id=%0d pg=%0d f=%0b r=%0d, required all 0",
                   rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason);
        end
      end else begin
        n_fail++;
        $display("FAIL sb_write_en_x: got %b, required 0 or 1", rsp_write_en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_write_en = 1'b0; s0_id = '0; s0_page_idx = '0; s0_fail = 1'b0; s0_fail_reason = '0;
    s1_write_en = 1'b0; s1_id = '0; s1_page_idx = '0; s1_fail = 1'b0; s1_fail_reason = '0;
  endtask

  task automatic drive(input int src, input int id, input bit f, input int r);
    if (src == 0) begin
      s0_write_en = 1'b1; s0_id = IDW'(id); s0_page_idx = PGW'(id + 100);
      s0_fail = f; s0_fail_reason = FRW'(r);
    end else begin
      s1_write_en = 1'b1; s1_id = IDW'(id); s1_page_idx = PGW'(id + 100);
      s1_fail = f; s1_fail_reason = FRW'(r);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rsp_fifo_almost_full = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    n_checks++;
    if ({rsp_write_en, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got we=%b id=%0d, required all 0", rsp_write_en, rsp_id);
    end
    n_checks++;
    if ({s0_drop_count, s1_drop_count, s0_almost_full, s1_almost_full, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_status: got d0=%0d d1=%0d af0=%b af1=%b busy=%b, required all 0",
               s0_drop_count, s1_drop_count, s0_almost_full, s1_almost_full, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 5, 1'b1, 1);
    sb.push_back(mk(5, 1'b1, 1));
    tick();
    clear_inputs();
    n_checks++;
    if (rsp_write_en !== 1'b0) begin
      n_fail++; $display("FAIL single_t1: got we=%b, required 0", rsp_write_en);
    end
    tick();
    n_checks++;
    if ({rsp_write_en, rsp_id, rsp_fail, rsp_fail_reason} !== {1'b1, IDW'(5), 1'b1, FRW'(1)}) begin
      n_fail++;
      $display("FAIL single_t2: got we=%b id=%0d f=%b r=%0d, required we=1 id=5 f=1 r=1",
               rsp_write_en, rsp_id, rsp_fail, rsp_fail_reason);
    end
    tick();
    n_checks++;
    if (rsp_write_en !== 1'b0) begin
      n_fail++; $display("FAIL single_one_shot: got we=%b, required 0", rsp_write_en);
    end
  endtask

  task automatic test_tie();
    int exp_ids[4] = '{3, 7, 4, 8};
    do_reset();
    for (int round = 0; round < 2; round++) begin
      drive(0, exp_ids[round*2], 1'b0, 2);
      drive(1, exp_ids[round*2+1], 1'b0, 6);
      sb.push_back(mk(exp_ids[round*2], 1'b0, 2));
      sb.push_back(mk(exp_ids[round*2+1], 1'b0, 6));
      tick();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
        tick();
        n_checks++;
        if ({rsp_write_en, rsp_id} !== {1'b1, IDW'(exp_ids[round*2+k])}) begin
          n_fail++;
          $display("FAIL tie_order: got we=%b id=%0d, required we=1 id=%0d",
                   rsp_write_en, rsp_id, exp_ids[round*2+k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_fifo_almost_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 10 + i, 1'b0, 3);
      if (i < 4) sb.push_back(mk(10 + i, 1'b0, 3));
      tick();
      clear_inputs();
      if (i < 4) begin
        n_checks++;
        if (s1_almost_full !== (i >= 2)) begin
          n_fail++;
          $display("FAIL bp_s1_almost_full: got %b after push %0d, required %b",
                   s1_almost_full, i + 1, (i >= 2));
        end
      end
    end
    n_checks++;
    if (s1_drop_count !== 8'd1) begin
      n_fail++; $display("FAIL bp_drop_count: got %0d, required 1", s1_drop_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (rsp_write_en !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: got we=%b, required 0", rsp_write_en);
      end
    end
    rsp_fifo_almost_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({rsp_write_en, rsp_id} !== {1'b1, IDW'(10 + i)}) begin
        n_fail++;
        $display("FAIL bp_release: got we=%b id=%0d, required we=1 id=%0d", rsp_write_en, rsp_id, 10 + i);
      end
    end
    tick();
    n_checks++;
    if (rsp_write_en !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained: got we=%b, required 0", rsp_write_en);
    end
  endtask

  task automatic test_full_pop();
    int exp_ids[5] = '{30, 31, 32, 33, 20};
    do_reset();
    rsp_fifo_almost_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 30 + i, 1'b1, 7);
      tick();
      clear_inputs();
    end
    for (int i = 0; i < 5; i++) sb.push_back(mk(exp_ids[i], 1'b1, 7));
    rsp_fifo_almost_full = 1'b0;
    drive(1, 20, 1'b1, 7);
    tick();
    clear_inputs();
    n_checks++;
    if ({s1_drop_count, s1_almost_full} !== {8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL full_pop_accept: got drop=%0d af=%b, required drop=0 af=1", s1_drop_count, s1_almost_full);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      n_checks++;
      if ({rsp_write_en, rsp_id} !== {1'b1, IDW'(exp_ids[i])}) begin
        n_fail++;
        $display("FAIL full_pop_order: got we=%b id=%0d, required we=1 id=%0d", rsp_write_en, rsp_id, exp_ids[i]);
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      sb.push_back(mk(40 + k, 1'b0, 3));
      sb.push_back(mk(60 + k, 1'b1, 4));
    end
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) begin
        drive(0, 40 + c / 2, 1'b0, 3);
        drive(1, 60 + c / 2, 1'b1, 4);
      end
      tick();
      clear_inputs();
      n_checks++;
      if ({busy, s0_almost_full, s1_almost_full} !== 3'b100) begin
        n_fail++;
        $display("FAIL alt_busy_level: got busy=%b af0=%b af1=%b at cycle %0d, required busy=1 af=0",
                 busy, s0_almost_full, s1_almost_full, c);
      end
    end
    tick();
    n_checks++;
    if ({busy, rsp_write_en, rsp_id} !== {1'b1, 1'b1, IDW'(69)}) begin
      n_fail++;
      $display("FAIL alt_last: got busy=%b we=%b id=%0d, required busy=1 we=1 id=69", busy, rsp_write_en, rsp_id);
    end
    tick();
    n_checks++;
    if ({busy, s0_drop_count, s1_drop_count} !== {1'b0, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL alt_idle: got busy=%b d0=%0d d1=%0d, required 0 0 0", busy, s0_drop_count, s1_drop_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    rsp_fifo_almost_full = 1'b1;
    for (int i = 0; i < 264; i++) begin
      drive(0, (i < 4) ? 80 + i : 200, 1'b0, 9);
      if (i < 4) sb.push_back(mk(80 + i, 1'b0, 9));
      tick();
      clear_inputs();
      if (i == 103) begin
        n_checks++;
        if (s0_drop_count !== 8'd100) begin
          n_fail++; $display("FAIL sat_mid: got %0d, required 100", s0_drop_count);
        end
      end
    end
    n_checks++;
    if (s0_drop_count !== 8'd255) begin
      n_fail++; $display("FAIL sat_cap: got %0d, required 255", s0_drop_count);
    end
    rsp_fifo_almost_full = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_fifo_almost_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 50 + i, 1'b0, 1);
      tick();
      clear_inputs();
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({rsp_write_en, rsp_id, busy, s0_almost_full, s0_drop_count} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got we=%b id=%0d busy=%b af0=%b d0=%0d, required all 0",
               rsp_write_en, rsp_id, busy, s0_almost_full, s0_drop_count);
    end
    rst = 1'b0;
    rsp_fifo_almost_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({rsp_write_en, busy} !== 2'b00) begin
        n_fail++; $display("FAIL mid_reset_discard: got we=%b busy=%b, required 0 0", rsp_write_en, busy);
      end
    end
    drive(0, 9, 1'b0, 5);
    sb.push_back(mk(9, 1'b0, 5));
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if ({rsp_write_en, rsp_id} !== {1'b1, IDW'(9)}) begin
      n_fail++; $display("FAIL mid_reset_push: got we=%b id=%0d, required we=1 id=9", rsp_write_en, rsp_id);
    end
    tick();
    n_checks++;
    if (rsp_write_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_alone: got we=%b, required 0", rsp_write_en);
    end
  endtask

  initial begin
    rst = 1'b1;
    rsp_fifo_almost_full = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_full_pop();
    test_alternate();
    test_saturate();
    test_reset_mid();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
